// File: rtl/seq_restoring_divider_pkg.sv
// Shared constants for the iterative restoring divider.
// No logic; state encoding and default operand width only.
// Not applicable (package).
package seq_restoring_divider_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/Full_adder.sv
// One-bit full adder cell used to build ripple arithmetic.
// Combinational, zero cycles.
// No flow control.
module Full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_restoring_divider_div_step.sv
// Single restoring division stage: trial-subtract D from the shifted remainder.
// Combinational, zero cycles.
// No flow control.
module div_step
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   sr_i,     // remainder after the left shift, WIDTH+1 bits
   input  logic [WIDTH-1:0] d_i,      // divisor
   output logic [WIDTH-1:0] r_o,      // next remainder
   output logic             q_bit_o   // quotient bit produced by this stage
);

   logic [WIDTH:0]   b_inv;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] carry;

   // sr - d as sr + ~d + 1 over WIDTH+1 bits
   assign b_inv    = ~{1'b0, d_i};
   assign carry[0] = 1'b1;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
      Full_adder u_fa (
         .a    (sr_i[i]),
         .b    (b_inv[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   // Non-negative trial: no borrow out and sign bit clear. With R < D kept
   // between iterations both conditions coincide.
   assign q_bit_o = carry[WIDTH+1] & ~diff[WIDTH];
   assign r_o     = q_bit_o ? diff[WIDTH-1:0] : sr_i[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// done pulses WIDTH+1 edges after the start edge (2 edges for a zero divisor).
// start is accepted only in IDLE; starts while busy are dropped, no queuing.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_r;
   logic             step_q;
   logic [WIDTH-1:0] q_shift;

   assign q_shift = {q_q[WIDTH-2:0], step_q};

   div_step #(.WIDTH(WIDTH)) u_step (
      .sr_i    ({r_q, q_q[WIDTH-1]}),
      .d_i     (d_q),
      .r_o     (step_r),
      .q_bit_o (step_q)
   );

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state and datapath update; results only move on the edge into DONE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               q_d     = dividend;
               d_d     = divisor;
               r_d     = '0;
               cnt_d   = '0;
               dbz_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (d_q == '0) begin
               // Zero divisor: a single pass with no iteration, so done still
               // lands two edges after start; Q still holds the dividend.
               quo_d   = '1;
               rem_d   = q_q;
               dbz_d   = 1'b1;
               state_d = DONE;
            end else begin
               r_d   = step_r;
               q_d   = q_shift;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  quo_d   = q_shift;
                  rem_d   = step_r;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
